// File: rtl/scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared types and constants for the four-digit scan
//                controller (load FSM states, digit/nibble geometry, anode-off
//                pattern).
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

  localparam int NIBBLES = 4;
  localparam int SEL_W   = 2;
  localparam int NIB_W   = 4;

  // All anodes dark (anodes are active-low).
  localparam logic [NIBBLES-1:0] C_AN_OFF = 4'b1111;

  // FILL: collecting nibbles into the shadow; PEND: full word waits for a
  // frame boundary before it is committed to the display.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Digit-slot prescaler. Counts 0..DIV-1 and wraps; flags the
//                last cycle of a slot (tick) and the first cycle (first).
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic first
);

  localparam int            PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] C_LAST = PW'(DIV - 1);

  logic [PW-1:0] r_presc;

  // Free-running slot counter, wraps after DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_presc == C_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign tick  = (r_presc == C_LAST);
  assign first = (r_presc == '0);

endmodule : tick_gen
`default_nettype wire

// File: rtl/scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : scan_controller
//  Description : Four-digit display front end. Collects a 16-bit word as four
//                nibbles over valid/ready into a shadow register, commits it
//                to the display word only at frame boundaries, and drives the
//                digit select, mux enable and active-low anodes.
//                Optional build macro SCAN_BLANK_EN blanks the first cycle of
//                every digit slot (anti-ghosting).
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_controller
  import scan_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  load_data,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [3:0]  digit_en,
  output logic [15:0] data,
  output logic [1:0]  sel,
  output logic        Enable,
  output logic [3:0]  an
);

`ifdef SCAN_BLANK_EN
  localparam logic C_BLANK = 1'b1;
`else
  localparam logic C_BLANK = 1'b0;
`endif

  state_t                     r_state;
  state_t                     w_next;
  logic [NIBBLES*NIB_W-1:0]   r_shadow;
  logic [NIBBLES*NIB_W-1:0]   r_data;
  logic [SEL_W-1:0]           r_nib_cnt;
  logic [SEL_W-1:0]           r_sel;
  logic                       w_tick;
  logic                       w_first;
  logic                       w_accept;
  logic                       w_last_nib;
  logic                       w_boundary;
  logic                       w_enable;

  tick_gen #(
    .DIV   (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick),
    .first (w_first)
  );

  assign load_ready = !reset && (r_state == FILL);
  assign w_accept   = load_valid && load_ready;
  assign w_last_nib = (r_nib_cnt == SEL_W'(NIBBLES - 1));
  assign w_boundary = w_tick && (r_sel == SEL_W'(NIBBLES - 1));

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: a word completes in FILL; the commit happens only in PEND,
  // so a 4th nibble landing on a boundary edge waits for the next boundary.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (w_accept && w_last_nib) w_next = PEND;
      PEND:    if (w_boundary)             w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  // Shadow fill, digit scan and frame-synchronous commit of the display word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow  <= '0;
      r_nib_cnt <= '0;
      r_sel     <= '0;
      r_data    <= '0;
    end else begin
      if (w_accept) begin
        r_shadow  <= {load_data, r_shadow[NIBBLES*NIB_W-1:NIB_W]};
        r_nib_cnt <= w_last_nib ? '0 : r_nib_cnt + SEL_W'(1);
      end
      if (w_tick) begin
        r_sel <= r_sel + SEL_W'(1);
      end
      if ((r_state == PEND) && w_boundary) begin
        r_data <= r_shadow;
      end
    end
  end

  assign data     = r_data;
  assign sel      = r_sel;
  assign w_enable = !reset && digit_en[r_sel] && !(C_BLANK && w_first);
  assign Enable   = w_enable;

  // One-hot active-low anode for the current slot, dark when disabled.
  always_comb begin
    an = C_AN_OFF;
    for (int i = 0; i < NIBBLES; i++) begin
      an[i] = !((r_sel == SEL_W'(i)) && w_enable);
    end
  end

endmodule : scan_controller
`default_nettype wire

// File: tb/tb_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_scan_controller
//  Description : Directed self-checking bench for scan_controller (DIV=4).
//                Honors SCAN_BLANK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_controller;

  localparam int DIV = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  load_data;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  digit_en;
  logic [15:0] data;
  logic [1:0]  sel;
  logic        Enable;
  logic [3:0]  an;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  scan_controller #(
    .DIV        (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digit_en   (digit_en),
    .data       (data),
    .sel        (sel),
    .Enable     (Enable),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock; cyc counts edges since the last reset release.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  // Expected enable for cycle c (presc = c%4, sel = (c/4)%4).
  function automatic logic exp_en(input int c, input logic [3:0] en);
    logic e;
    e = en[(c / DIV) % 4];
`ifdef SCAN_BLANK_EN
    if ((c % DIV) == 0) e = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [3:0] exp_an(input int c, input logic [3:0] en);
    logic [3:0] one;
    one = 4'b0001 << ((c / DIV) % 4);
    return exp_en(c, en) ? ~one : 4'b1111;
  endfunction

  task automatic scan_check(input int n);
    for (int k = 0; k < n; k++) begin
      check("scan_sel", 32'(sel), 32'((cyc / DIV) % 4));
      check("scan_en", 32'(Enable), 32'(exp_en(cyc, digit_en)));
      check("scan_an", 32'(an), 32'(exp_an(cyc, digit_en)));
      step();
    end
  endtask

  // Offer one nibble, hold valid until accepted (bounded), consume the edge.
  task automatic send(input logic [3:0] n);
    logic acc;
    acc        = 1'b0;
    load_valid = 1'b1;
    load_data  = n;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (load_ready) begin
        acc = 1'b1;
        break;
      end
      step();
    end
    check("send_accepted", 32'(acc), 32'd1);
    step();
    load_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check("rst_data", 32'(data), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_en", 32'(Enable), 32'h0);
      check("rst_an", 32'(an), 32'hF);
      check("rst_ready", 32'(load_ready), 32'h0);
    end
    load_valid = 1'b0;
    reset      = 1'b0;
    cyc        = 0;
    #1;
    check("rel_ready", 32'(load_ready), 32'h1);
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 4'hF;
    digit_en   = 4'b1111;

    // Reset with valid asserted.
    do_reset(3);

    // Free scan, no loads.
    scan_check(20);

    // Load 1,2,3,4 from start of a frame (cycle 32).
    wait_to(32);
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    check("load_ready_low", 32'(load_ready), 32'h0);
    wait_to(47);
    check("load_pre_commit", 32'(data), 32'h0);
    step();
    check("load_commit", 32'(data), 32'h4321);
    check("load_ready_rise", 32'(load_ready), 32'h1);

    // Backpressure: word pending, A..D wait with valid held high.
    send(4'h2); send(4'h4); send(4'h6); send(4'h8);
    send(4'hA);
    check("bp_a_cycle", 32'(cyc), 32'd65);
    send(4'hB); send(4'hC); send(4'hD);
    check("bp_first_word", 32'(data), 32'h8642);
    wait_to(79);
    check("bp_pre_commit", 32'(data), 32'h8642);
    step();
    check("bp_commit", 32'(data), 32'hDCBA);

    // 4th nibble accepted on a frame-boundary edge (edge 96).
    wait_to(92);
    send(4'h3); send(4'hC); send(4'h5); send(4'hA);
    check("coin_no_commit", 32'(data), 32'hDCBA);
    check("coin_ready", 32'(load_ready), 32'h0);
    wait_to(111);
    check("coin_hold", 32'(data), 32'hDCBA);
    step();
    check("coin_commit", 32'(data), 32'hA5C3);

    // digit_en takes effect combinationally (cycle 113: sel 0, presc 1).
    step();
    digit_en = 4'b1110;
    #1;
    check("dyn_en_off", 32'(Enable), 32'h0);
    check("dyn_an_off", 32'(an), 32'hF);
    digit_en = 4'b1111;
    #1;
    check("dyn_en_on", 32'(Enable), 32'h1);
    check("dyn_an_on", 32'(an), 32'hE);

    // Masking digits 1 and 3.
    digit_en = 4'b0101;
    scan_check(16);
    digit_en = 4'b1111;

    // Reset mid-fill discards the partial shadow.
    send(4'h9); send(4'h9);
    do_reset(1);
    send(4'h5); send(4'h6); send(4'h7); send(4'h8);
    wait_to(15);
    check("mf_pre_commit", 32'(data), 32'h0);
    step();
    check("mf_commit", 32'(data), 32'h8765);

    // Reset mid-PEND discards the pending word.
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    wait_to(24);
    check("mp_pending", 32'(load_ready), 32'h0);
    do_reset(1);
    wait_to(16);
    check("mp_data", 32'(data), 32'h0);
    check("mp_ready", 32'(load_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_scan_controller
`default_nettype wire

// File: doc/scan_controller.md
# scan_controller

Front end of the four-digit display path. Accepts a 16-bit word as four 4-bit nibbles over a valid/ready handshake and double-buffers it so the displayed word only changes between scan frames. Divides the clock into digit slots and drives `data`, `sel` and `Enable` of the downstream 4:1 nibble multiplexer, plus active-low digit anodes for the same slot.

## Interface

- `DIV`, default 100000: clock cycles per digit slot; legal range 2..2^20.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `load_data` input 4: nibble offered for loading.
- `load_valid` input 1: `load_data` is valid.
- `load_ready` output 1: block accepts a nibble this cycle.
- `digit_en` input 4: per-digit enable mask; bit i enables digit i.
- `data` output 16: committed display word to the multiplexer; digit i is `data[4i+3:4i]`.
- `sel` output 2: current digit slot index to the multiplexer.
- `Enable` output 1: multiplexer output enable.
- `an` output 4: active-low one-hot anode for the current digit.

## Operation

- Handshake:
  - A nibble is accepted on a rising edge where `load_valid && load_ready`.
  - On acceptance, `shadow <= {load_data, shadow[15:4]}` and `nib_cnt` increments.
  - The first accepted nibble of a frame ends up in `data[3:0]`.
- FSM has two states:
  - FILL: `load_ready=1`. The 4th accept (`nib_cnt==3`) moves to PEND and clears `nib_cnt`.
  - PEND: `load_ready=0`. On a frame-boundary tick, `data <= shadow` and the FSM returns to FILL.
- Scan:
  - `presc` counts 0..DIV-1 and wraps.
  - A tick is `presc==DIV-1`. On each tick, `sel` increments mod 4.
  - A frame boundary is a tick with `sel==3`; on that edge `sel` becomes 0 and any pending commit lands in `data` on the same edge.
- Outputs:
  - `data` and `sel` are registered.
  - `Enable = !reset && digit_en[sel]` (see Configuration).
  - `an[i] = !(sel==i && Enable)`.
- Boundary conditions:
  - If the 4th nibble is accepted on the same edge as a frame-boundary tick, it does not commit on that edge. It commits at the following boundary.
  - `load_valid` held high in PEND is ignored, and nothing is lost.
  - `digit_en` changes take effect combinationally.
  - Reset mid-fill discards the partial shadow; the next accepted nibble is nibble 0 again.
  - Reset mid-PEND discards the pending word; `data` stays 0.

## Timing

- Reset values: `data=16'h0000`, `sel=0`, `presc=0`, `nib_cnt=0`, `shadow=0`, FSM=FILL.
- While `reset` is high: `load_ready=0`, `Enable=0`, `an=4'b1111`.
- `load_ready` is 1 on the first cycle after reset is released.
- `load_ready` falls on the edge after the 4th accept. It rises on the commit edge.
- Commit latency from the 4th accept is 1..4*DIV cycles.
- Each `sel` value lasts exactly DIV cycles. A full frame is 4*DIV cycles.
- `an` and `Enable` follow `sel` with zero added latency.
- Maximum sustained load rate is four nibbles per frame.

## Configuration

- `SCAN_BLANK_EN` defined: `Enable` is also forced 0 while `presc==0`. This blanks the first cycle of every digit slot to suppress ghosting; `an` is all-ones in that cycle.
- `SCAN_BLANK_EN` undefined: no blanking; `Enable` depends only on `reset` and `digit_en[sel]`.
- `data`, `sel` and the handshake are identical in both builds.

## Structure

- Package `scan_pkg` holds:
  - the FSM state type (FILL, PEND);
  - `NIBBLES=4`, `SEL_W=2`, `NIB_W=4`;
  - the anode-off constant `4'b1111`.
- Sub-module `tick_gen` (parameter `DIV`; ports `clk`, `reset`, `tick`, `first`) owns `presc`.
  - `tick` is high when `presc==DIV-1`.
  - `first` is high when `presc==0`.
- The top level holds the FSM, `shadow`, `nib_cnt`, `data`, `sel` and output decode.

## Test plan

All scenarios use `DIV=4`.

- Reset: hold `reset` 3 cycles with `load_valid=1` -> `data=0`, `sel=0`, `Enable=0`, `an=1111`, `load_ready=0`, nothing accepted; the first cycle after release has `load_ready=1`.
- Free scan: `digit_en=1111`, no loads -> `sel` steps 0,1,2,3,0, four cycles each; `an` steps 1110, 1101, 1011, 0111.
- Load: nibbles 1,2,3,4 back-to-back from `sel=0` -> `load_ready=0` after the 4th; `data=16'h4321` on the next `sel` 3->0 edge, with `load_ready=1` on that edge.
- Backpressure: hold `load_valid=1` with A,B,C,D queued -> nothing accepted in PEND; after commit, A..D are accepted and the next boundary gives `data=16'hDCBA`.
- Reset mid-fill: load 9,9, pulse `reset`, then load 5,6,7,8 -> `data=16'h8765` at the next boundary.
- Masking/blanking: `digit_en=0101` -> `Enable=0` and `an=1111` whenever `sel` is 1 or 3. With `SCAN_BLANK_EN` defined, `Enable=0` also holds on the first cycle of every slot.
